// File: rtl/mem_image_loader.sv
`default_nettype none
// =====================================================================
// mem_image_loader : byte-stream frame assembler driving a memory-load port
// Revision        : 1.0
// =====================================================================
module mem_image_loader #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instructionAddress,
  output logic [31:0]       data,
  output logic [ADDR_W-1:0] dataAddress,
  output logic              writeEnable,
  output logic [15:0]       words_loaded,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_BYTES  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                tgt_q, tgt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         asm_q, asm_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [15:0]         idle_q, idle_d;
  // Output registers double as the shadows re-written on every strobe.
  logic [31:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic                we_q, we_d;
  logic [15:0]         words_q, words_d;
  logic                err_q, err_d;
  logic                w_xfer;

  assign in_ready = rst_n && (state_q == S_HDR || state_q == S_BYTES);
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    instr_d = instr_q;
    iaddr_d = iaddr_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    we_d    = 1'b0;
    words_d = words_q;
    err_d   = err_q;
    case (state_q)
      S_HDR: begin
        if (w_xfer) begin
          tgt_d   = in_byte[7];
          addr_d  = in_byte[ADDR_W-1:0];
          cnt_d   = 2'd0;
          idle_d  = 16'd0;
          state_d = S_BYTES;
        end
      end
      S_BYTES: begin
        if (w_xfer) begin
          asm_d  = {asm_q[23:0], in_byte};
          idle_d = 16'd0;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_SETUP;
          end
        end else if (idle_q == C_TIMEOUT) begin
          // Abandon the partial frame; outputs keep their previous image.
          err_d   = 1'b1;
          state_d = S_HDR;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      S_SETUP: begin
        if (tgt_q) begin
          data_d  = asm_q;
          daddr_d = addr_q;
        end else begin
          instr_d = asm_q;
          iaddr_d = addr_q;
        end
        state_d = S_STROBE;
      end
      S_STROBE: begin
        we_d    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (words_q != 16'hFFFF) begin
          words_d = words_q + 16'd1;
        end
        state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR;
      tgt_q   <= 1'b0;
      addr_q  <= '0;
      asm_q   <= 32'd0;
      cnt_q   <= 2'd0;
      idle_q  <= 16'd0;
      instr_q <= 32'd0;
      iaddr_q <= '0;
      data_q  <= 32'd0;
      daddr_q <= '0;
      we_q    <= 1'b0;
      words_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      we_q    <= we_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign instruction        = instr_q;
  assign instructionAddress = iaddr_q;
  assign data               = data_q;
  assign dataAddress        = daddr_q;
  assign writeEnable        = we_q;
  assign words_loaded       = words_q;
  assign frame_err          = err_q;
  assign busy               = (state_q != S_HDR);

endmodule
`default_nettype wire

// File: tb/tb_mem_image_loader.sv
`default_nettype none
// =====================================================================
// tb_mem_image_loader : randomized stream vs. frame-level reference model
// Revision            : 1.0
// =====================================================================
module tb_mem_image_loader;

  localparam int TMO = 4;
  localparam int AW  = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   instruction;
  logic [AW-1:0] instructionAddress;
  logic [31:0]   data;
  logic [AW-1:0] dataAddress;
  logic          writeEnable;
  logic [15:0]   words_loaded;
  logic          frame_err;
  logic          busy;

  mem_image_loader #(.TIMEOUT_CYCLES(TMO), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .instruction(instruction),
    .instructionAddress(instructionAddress), .data(data),
    .dataAddress(dataAddress), .writeEnable(writeEnable),
    .words_loaded(words_loaded), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int gap; } item_t;
  item_t q[$];
  bit    fresh = 1'b1;
  int    gap_left = 0;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  bit prev_we = 1'b0;

  // Reference model: frame bookkeeping plus edge numbers of scheduled effects.
  int            cyc, pend, idle, nbytes;
  bit            infrm, m_tgt, p_tgt;
  logic [AW-1:0] m_addr, p_addr;
  logic [31:0]   m_word, p_word;
  logic [31:0]   m_instr, m_data;
  logic [AW-1:0] m_iaddr, m_daddr;
  logic          m_we, m_ferr;
  logic [15:0]   m_words;

  function automatic bit in_post();
    return (cyc - pend >= 0) && (cyc - pend <= 2);
  endfunction

  function automatic bit m_ready();
    return rst_n && !in_post();
  endfunction

  function automatic bit m_busy();
    return infrm || in_post();
  endfunction

  task automatic model_reset();
    cyc = 0; pend = -100; idle = 0; nbytes = 0; infrm = 1'b0;
    m_tgt = 1'b0; p_tgt = 1'b0; m_addr = '0; p_addr = '0;
    m_word = 32'd0; p_word = 32'd0;
    m_instr = 32'd0; m_data = 32'd0; m_iaddr = '0; m_daddr = '0;
    m_we = 1'b0; m_ferr = 1'b0; m_words = 16'd0;
  endtask

  // Advance the model across the rising edge that just passed.
  task automatic model_edge();
    bit xfer;
    xfer = in_valid && m_ready();
    cyc++;
    if (cyc == pend + 1) begin
      if (p_tgt) begin m_data = p_word; m_daddr = p_addr; end
      else       begin m_instr = p_word; m_iaddr = p_addr; end
    end
    m_we = (cyc == pend + 2);
    if (cyc == pend + 3 && m_words != 16'hFFFF) m_words = m_words + 16'd1;
    if (xfer) begin
      void'(q.pop_front());
      fresh = 1'b1;
      idle = 0;
      if (!infrm) begin
        infrm = 1'b1; nbytes = 0; m_tgt = in_byte[7]; m_addr = in_byte[AW-1:0];
      end else begin
        m_word = {m_word[23:0], in_byte};
        nbytes++;
        if (nbytes == 4) begin
          infrm = 1'b0; pend = cyc; p_tgt = m_tgt; p_addr = m_addr; p_word = m_word;
        end
      end
    end else if (infrm) begin
      if (idle == TMO) begin m_ferr = 1'b1; infrm = 1'b0; end
      else idle++;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("busy", 64'(busy), 64'(rst_n && m_busy()));
    chk("writeEnable", 64'(writeEnable), 64'(m_we));
    chk("instruction", 64'(instruction), 64'(m_instr));
    chk("instructionAddress", 64'(instructionAddress), 64'(m_iaddr));
    chk("data", 64'(data), 64'(m_data));
    chk("dataAddress", 64'(dataAddress), 64'(m_daddr));
    chk("words_loaded", 64'(words_loaded), 64'(m_words));
    chk("frame_err", 64'(frame_err), 64'(m_ferr));
    if (writeEnable && !prev_we) strobes++;
    prev_we = writeEnable;
  endtask

  task automatic drive();
    if (q.size() == 0) begin
      in_valid = 1'b0;
    end else begin
      if (fresh) begin gap_left = q[0].gap; fresh = 1'b0; end
      if (gap_left > 0) begin
        gap_left--;
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_byte  = q[0].b;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_n) model_edge();
    compare_all();
    drive();
  endtask

  task automatic push_frame(logic [7:0] hdr, logic [31:0] w, int gap);
    q.push_back('{hdr, gap});
    q.push_back('{w[31:24], gap});
    q.push_back('{w[23:16], gap});
    q.push_back('{w[15:8], gap});
    q.push_back('{w[7:0], gap});
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((q.size() > 0 || m_busy()) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk({tag, "_drain_budget"}, 64'(n), 64'd0);
    repeat (3) step();
  endtask

  initial begin
    int s0;
    model_reset();
    // Reset held with a byte on offer: nothing may be accepted.
    in_valid = 1'b1;
    in_byte  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      compare_all();
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      chk("reset_instruction", 64'(instruction), 64'd0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Instruction frame.
    s0 = strobes;
    push_frame(8'h05, 32'h20118020, 0);
    drain("instr");
    chk("pin_model_instr", 64'(m_instr), 64'h20118020);
    chk("pin_instr", 64'(instruction), 64'h20118020);
    chk("pin_iaddr", 64'(instructionAddress), 64'd5);
    chk("pin_data_zero", 64'(data), 64'd0);
    chk("pin_words1", 64'(words_loaded), 64'd1);
    chk("pin_strobe1", 64'(strobes - s0), 64'd1);

    // Data frame following it.
    push_frame(8'h83, 32'h0000002A, 0);
    drain("data");
    chk("pin_model_data", 64'(m_data), 64'h2A);
    chk("pin_data", 64'(data), 64'h2A);
    chk("pin_daddr", 64'(dataAddress), 64'd3);
    chk("pin_instr_kept", 64'(instruction), 64'h20118020);
    chk("pin_words2", 64'(words_loaded), 64'd2);

    // Throttled source, and gaps just under the timeout.
    s0 = strobes;
    push_frame(8'h10, 32'h12345678, 1);
    push_frame(8'h91, 32'hCAFEF00D, TMO - 1);
    drain("throttle");
    chk("pin_thr_instr", 64'(instruction), 64'h12345678);
    chk("pin_thr_data", 64'(data), 64'hCAFEF00D);
    chk("pin_thr_strobes", 64'(strobes - s0), 64'd2);
    chk("pin_thr_ferr", 64'(frame_err), 64'd0);

    // Timeout abort, then a good frame.
    s0 = strobes;
    q.push_back('{8'h01, 0});
    q.push_back('{8'hAA, 0});
    push_frame(8'h02, 32'hDEADBEEF, 0);
    q[2].gap = TMO + 4;
    drain("timeout");
    chk("pin_to_ferr", 64'(frame_err), 64'd1);
    chk("pin_to_instr", 64'(instruction), 64'hDEADBEEF);
    chk("pin_to_iaddr", 64'(instructionAddress), 64'd2);
    chk("pin_to_strobes", 64'(strobes - s0), 64'd1);

    // Randomized frames with random source throttling.
    s0 = strobes;
    for (int i = 0; i < 40; i++) begin
      push_frame(8'($urandom_range(0, 255)), $urandom, $urandom_range(0, TMO - 1));
    end
    drain("random");
    chk("rand_strobes", 64'(strobes - s0), 64'd40);

    // Reset while the strobe is high.
    push_frame(8'h07, 32'h01020304, 0);
    begin
      int n;
      n = 0;
      while (!m_we && n < 100) begin step(); n++; end
      chk("strobe_reached", 64'(writeEnable), 64'd1);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    q.delete();
    fresh = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_we_drop", 64'(writeEnable), 64'd0);
    chk("rst_instr_zero", 64'(instruction), 64'd0);
    chk("rst_words_zero", 64'(words_loaded), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    s0 = strobes;
    push_frame(8'h84, 32'hA5A5_5A5A, 0);
    drain("after_reset");
    chk("pin_ar_data", 64'(data), 64'hA5A55A5A);
    chk("pin_ar_daddr", 64'(dataAddress), 64'd4);
    chk("pin_ar_words", 64'(words_loaded), 64'd1);
    chk("pin_ar_ferr", 64'(frame_err), 64'd0);
    chk("pin_ar_strobes", 64'(strobes - s0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
